// File: rtl/kernel_result_axis_tx.sv
// kernel_result_axis_tx: reframes the 3x3 kernel result stream as AXI4-Stream video,
// regenerating tuser (SOF) and tlast (EOL) from x/y counters, flagging input framing
// that disagrees with the counters, and buffering beats so back-pressure reaches the kernel.
// Ports:
//   i_clk, i_rstn                  clock, synchronous active-low reset
//   i_tdata/i_tvalid/o_tready      input beats packed {px, tuser_in, tlast_in}
//   o_tdata/o_tuser/o_tlast/o_tvalid/i_tready  output video stream
//   o_sof_err, o_eol_err           one-cycle pulses for framing disagreements
//   o_frame_done                   one-cycle pulse when the last pixel of a frame is accepted
module kernel_result_axis_tx #(
    parameter int LINE_LENGTH = 640,
    parameter int LINE_COUNT  = 480,
    parameter int DATA_WIDTH  = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic [DATA_WIDTH+1:0] i_tdata,
    input  logic                  i_tvalid,
    output logic                  o_tready,
    output logic [DATA_WIDTH-1:0] o_tdata,
    output logic                  o_tuser,
    output logic                  o_tlast,
    output logic                  o_tvalid,
    input  logic                  i_tready,
    output logic                  o_sof_err,
    output logic                  o_eol_err,
    output logic                  o_frame_done
);
    localparam int XW = LINE_LENGTH > 1 ? $clog2(LINE_LENGTH) : 1;
    localparam int YW = LINE_COUNT > 1 ? $clog2(LINE_COUNT) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = DATA_WIDTH + 2;
    localparam logic [XW-1:0] X_MAX = XW'(LINE_LENGTH - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(LINE_COUNT - 1);
    localparam logic [CW-1:0] FULL  = CW'(FIFO_DEPTH);

    typedef enum logic {SYNC, RUN} state_t;

    state_t        state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          in_fire, out_fire, sof_in, eol_in;
    logic          at_origin, x_last, y_last, resync, push;
    logic [EW-1:0] push_entry, head;

    assign o_tready  = (state == SYNC) || (count != FULL);
    assign in_fire   = i_tvalid && o_tready;
    assign out_fire  = o_tvalid && i_tready;
    assign sof_in    = i_tdata[1];
    assign eol_in    = i_tdata[0];
    assign at_origin = (x == '0) && (y == '0);
    assign x_last    = x == X_MAX;
    assign y_last    = y == Y_MAX;
    // A tuser_in beat restarts the frame: always while hunting for sync, and mid-frame on an early SOF.
    assign resync    = sof_in && (state == SYNC || !at_origin);
    assign push      = in_fire && (state == RUN || sof_in);
    assign push_entry = {i_tdata[EW-1:2], resync || at_origin, !resync && x_last};

    assign head     = mem[rd_ptr];
    assign o_tvalid = count != '0;
    // Gating by o_tvalid keeps the outputs at zero when empty without resetting the buffer storage.
    assign o_tdata  = o_tvalid ? head[EW-1:2] : '0;
    assign o_tuser  = o_tvalid && head[1];
    assign o_tlast  = o_tvalid && head[0];

    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state        <= SYNC;
            x            <= '0;
            y            <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            o_sof_err    <= 1'b0;
            o_eol_err    <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            o_sof_err    <= in_fire && state == RUN && (sof_in != at_origin);
            o_eol_err    <= in_fire && state == RUN && !resync && (eol_in != x_last);
            o_frame_done <= push && !resync && x_last && y_last;
            if (push) begin
                state  <= RUN;
                wr_ptr <= wr_ptr + 1'b1;
                x      <= resync ? XW'(1) : (x_last ? '0 : x + 1'b1);
                if (resync) y <= '0;
                else if (x_last) y <= y_last ? '0 : y + 1'b1;
            end
            if (out_fire) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(out_fire);
        end
    end
endmodule

// File: tb/tb_kernel_result_axis_tx.sv
// tb_kernel_result_axis_tx: directed self-checking bench for kernel_result_axis_tx (4x3 frames, 4-deep buffer).
module tb_kernel_result_axis_tx;
    logic       i_clk = 1'b0;
    logic       i_rstn = 1'b0;
    logic [2:0] i_tdata = '0;
    logic       i_tvalid = 1'b0;
    logic       i_tready = 1'b1;
    logic       o_tready, o_tuser, o_tlast, o_tvalid, o_sof_err, o_eol_err, o_frame_done;
    logic [0:0] o_tdata;

    kernel_result_axis_tx #(
        .LINE_LENGTH(4),
        .LINE_COUNT(3),
        .DATA_WIDTH(1),
        .FIFO_DEPTH(4)
    ) dut (
        .i_clk(i_clk),
        .i_rstn(i_rstn),
        .i_tdata(i_tdata),
        .i_tvalid(i_tvalid),
        .o_tready(o_tready),
        .o_tdata(o_tdata),
        .o_tuser(o_tuser),
        .o_tlast(o_tlast),
        .o_tvalid(o_tvalid),
        .i_tready(i_tready),
        .o_sof_err(o_sof_err),
        .o_eol_err(o_eol_err),
        .o_frame_done(o_frame_done)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [2:0] out_arr [0:255];
    int out_n = 0, sof_n = 0, eol_n = 0, fd_n = 0;
    logic [11:0] pat = 12'b0110_1001_1101;
    logic [2:0] exp_b [0:11];
    int base, s0, e0, f0, c0;

    always @(posedge i_clk) cyc++;

    // Transfers happen at the next rising edge; inputs only change just after rising edges.
    always @(negedge i_clk) begin
        if (i_rstn) begin
            if (o_tvalid && i_tready && out_n < 256) begin
                out_arr[out_n] = {o_tdata, o_tuser, o_tlast};
                out_n++;
            end
            sof_n += int'(o_sof_err);
            eol_n += int'(o_eol_err);
            fd_n  += int'(o_frame_done);
        end
    end

    task automatic check(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s[%0d]: observed %0h expected %0h", tag, idx, obs, exp);
        end
    endtask

    task automatic send(input logic [2:0] d);
        bit ok = 1'b0;
        i_tdata  = d;
        i_tvalid = 1'b1;
        for (int k = 0; k < 64; k++) begin
            @(negedge i_clk);
            if (o_tready) begin
                ok = 1'b1;
                break;
            end
            @(posedge i_clk);
        end
        if (!ok) check("send_timeout", 0, 0, 1);
        @(posedge i_clk);
        #1;
        i_tvalid = 1'b0;
    endtask

    task automatic snapshot();
        base = out_n;
        s0 = sof_n;
        e0 = eol_n;
        f0 = fd_n;
    endtask

    task automatic do_reset();
        i_rstn = 1'b0;
        i_tvalid = 1'b0;
        i_tready = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        i_rstn = 1'b1;
        snapshot();
    endtask

    task automatic wait_out(input int n);
        for (int k = 0; k < 100 && out_n < n; k++) @(posedge i_clk);
        repeat (3) @(posedge i_clk);
        #1;
        check("out_count", 0, out_n, n);
    endtask

    task automatic check_beats(input int n);
        for (int i = 0; i < n; i++) check("beat", i, out_arr[base+i], exp_b[i]);
    endtask

    task automatic check_counts(input int s, input int e, input int f);
        check("sof_pulses", 0, sof_n - s0, s);
        check("eol_pulses", 0, eol_n - e0, e);
        check("frame_done_pulses", 0, fd_n - f0, f);
    endtask

    task automatic fill_clean();
        for (int i = 0; i < 12; i++) exp_b[i] = {pat[i], i == 0, i % 4 == 3};
    endtask

    task automatic clean_frame();
        for (int i = 0; i < 12; i++) send({pat[i], i == 0, i % 4 == 3});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_tvalid", 0, o_tvalid, 0);
        check("rst_tready", 0, o_tready, 1);
        check("rst_tdata", 0, o_tdata, 0);
        check("rst_tuser", 0, o_tuser, 0);
        check("rst_tlast", 0, o_tlast, 0);
        check("rst_errs", 0, {o_sof_err, o_eol_err, o_frame_done}, 0);

        // Clean frame, latency and throughput
        do_reset();
        fill_clean();
        c0 = cyc;
        send({pat[0], 1'b1, 1'b0});
        check("lat_valid", 0, o_tvalid, 1);
        check("lat_user", 0, o_tuser, 1);
        check("lat_data", 0, o_tdata, pat[0]);
        for (int i = 1; i < 12; i++) send({pat[i], 1'b0, i % 4 == 3});
        check("fd_pulse", 0, o_frame_done, 1);
        check("throughput", 0, cyc - c0, 12);
        @(posedge i_clk);
        #1;
        check("fd_one_cycle", 0, o_frame_done, 0);
        wait_out(base + 12);
        check_beats(12);
        check_counts(0, 0, 1);

        // Pre-sync garbage is dropped with ready held high
        do_reset();
        c0 = cyc;
        for (int i = 0; i < 3; i++) send({pat[i], 1'b0, i == 1});
        check("garbage_cycles", 0, cyc - c0, 3);
        check("garbage_valid", 0, o_tvalid, 0);
        check("garbage_out", 0, out_n - base, 0);
        clean_frame();
        wait_out(base + 12);
        check_beats(12);
        check_counts(0, 0, 1);

        // Early SOF on beat 6 resyncs; later tlast_in follows the old framing
        do_reset();
        for (int i = 0; i < 12; i++) begin
            send({pat[i], i == 0 || i == 6, i % 4 == 3});
            if (i == 6) check("sof_pulse", 6, o_sof_err, 1);
            if (i == 7) check("sof_clear", 7, o_sof_err, 0);
            exp_b[i] = {pat[i], i == 0 || i == 6, i == 3 || i == 9};
        end
        wait_out(base + 12);
        check_beats(12);
        check_counts(1, 3, 0);

        // Bad EOL: missing on beat 3, spurious on beat 5
        do_reset();
        fill_clean();
        for (int i = 0; i < 12; i++) begin
            send({pat[i], i == 0, i == 5 ? 1'b1 : (i == 3 ? 1'b0 : i % 4 == 3)});
            if (i == 3) check("eol_pulse", 3, o_eol_err, 1);
            if (i == 4) check("eol_clear", 4, o_eol_err, 0);
        end
        wait_out(base + 12);
        check_beats(12);
        check_counts(0, 2, 1);

        // Back-pressure: 4 beats fill the buffer, head holds during the stall
        do_reset();
        fill_clean();
        i_tready = 1'b0;
        for (int i = 0; i < 4; i++) send({pat[i], i == 0, i % 4 == 3});
        check("bp_ready", 0, o_tready, 0);
        check("bp_valid", 0, o_tvalid, 1);
        i_tdata = {pat[4], 1'b0, 1'b0};
        i_tvalid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge i_clk);
            #1;
            check("hold_user", k, o_tuser, 1);
            check("hold_data", k, o_tdata, pat[0]);
            check("hold_ready", k, o_tready, 0);
        end
        i_tready = 1'b1;
        @(posedge i_clk);
        #1;
        check("ready_rise", 0, o_tready, 1);
        send({pat[4], 1'b0, 1'b0});
        send({pat[5], 1'b0, 1'b0});
        wait_out(base + 6);
        check_beats(6);
        check_counts(0, 0, 0);

        // Reset mid-frame with 2 beats buffered
        do_reset();
        fill_clean();
        for (int i = 0; i < 3; i++) send({pat[i], i == 0, 1'b0});
        @(posedge i_clk);
        #1;
        i_tready = 1'b0;
        send({pat[3], 1'b0, 1'b1});
        send({pat[4], 1'b0, 1'b0});
        check("pre_rst_valid", 0, o_tvalid, 1);
        i_rstn = 1'b0;
        @(posedge i_clk);
        #1;
        check("mid_rst_valid", 0, o_tvalid, 0);
        check("mid_rst_ready", 0, o_tready, 1);
        i_rstn = 1'b1;
        i_tready = 1'b1;
        snapshot();
        clean_frame();
        wait_out(base + 12);
        check_beats(12);
        check_counts(0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
